// File: rtl/dram_arbiter_pkg.sv
// Shared core defines: access sizes, byte-lane masks, read-owner tags and
// the helpers the arbiter and the MEM stage both rely on.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_aligned(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      SZ_WORD: return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: return BE_BYTE << off;
      SZ_HALF: return BE_HALF << off;
      SZ_WORD: return BE_WORD;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Bundle of the core request port, the host loader port and the RAM port.
// slave = the arbiter, master = requesters plus the RAM data return.
interface dram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              core_req;
  logic              core_we;
  logic [1:0]        core_size;
  logic              core_sign;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_gnt;
  logic              core_err;
  logic              core_rvalid;
  logic [31:0]       core_rdata;

  logic              host_req;
  logic              host_we;
  logic              host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [31:0]       host_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-3:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  core_req, core_we, core_size, core_sign, core_addr, core_wdata,
    output core_gnt, core_err, core_rvalid, core_rdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output core_req, core_we, core_size, core_sign, core_addr, core_wdata,
    input  core_gnt, core_err, core_rvalid, core_rdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dram_arbiter_load_align.sv
// Load formatter: picks the addressed byte/half out of a RAM word and
// sign- or zero-extends it. Words pass through untouched.
module load_align
  import dram_arbiter_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = data_i >> {offset_i, 3'b000};

  always_comb begin
    case (size_i)
      SZ_BYTE: result_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Core/host arbiter for the single-port data RAM: combinational grant with
// host anti-starvation, lane steering, and a one-deep read return pipeline.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dram_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          rd_valid_q;
  owner_e        rd_owner_q;
  size_e         rd_size_q;
  logic          rd_sign_q;
  logic [1:0]    rd_off_q;
  logic [31:0]   core_rdata_q;
  logic [31:0]   host_rdata_q;

  logic          host_sel, core_sel, core_legal, rd_fire;
  logic          en_int, we_int;
  size_e         core_size;
  logic [1:0]    core_off;
  logic [31:0]   steer, fmt_rdata;
  logic          unused_host_off;

  assign core_size       = size_e'(bus.core_size);
  assign core_off        = bus.core_addr[1:0];
  assign core_legal      = is_aligned(core_size, core_off);
  assign unused_host_off = ^bus.host_addr[1:0];

  // Host wins on lock, on a full starve count, or when the core is idle.
  assign host_sel = !rst && bus.host_req &&
                    (bus.host_lock || (starve_q == SW'(STARVE_MAX)) || !bus.core_req);
  assign core_sel = !rst && bus.core_req && !host_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign steer[gi*8 +: 8] =
          (core_size == SZ_BYTE) ? bus.core_wdata[7:0] :
          (core_size == SZ_HALF) ? bus.core_wdata[(gi % 2)*8 +: 8] :
                                   bus.core_wdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    en_int        = 1'b0;
    we_int        = 1'b0;
    bus.ram_be    = 4'b0000;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (host_sel) begin
      en_int        = 1'b1;
      we_int        = bus.host_we;
      bus.ram_be    = BE_WORD;
      bus.ram_addr  = bus.host_addr[ADDR_W-1:2];
      bus.ram_wdata = bus.host_wdata;
    end else if (core_sel) begin
      en_int        = core_legal;
      we_int        = bus.core_we;
      bus.ram_be    = core_legal ? lane_mask(core_size, core_off) : 4'b0000;
      bus.ram_addr  = bus.core_addr[ADDR_W-1:2];
      bus.ram_wdata = steer;
    end
  end

  assign bus.ram_en   = en_int;
  assign bus.ram_we   = we_int;
  assign bus.host_gnt = host_sel;
  assign bus.core_gnt = core_sel;
  assign bus.core_err = core_sel && !core_legal;
  assign rd_fire      = en_int && !we_int;

  always_comb begin
    starve_d = starve_q;
    if (!bus.host_req || host_sel)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  load_align u_load_align (
    .data_i   (bus.ram_rdata),
    .offset_i (rd_off_q),
    .size_i   (rd_size_q),
    .sign_i   (rd_sign_q),
    .result_o (fmt_rdata)
  );

  // Returned data is live during the rvalid cycle, then held until the next return.
  assign bus.core_rvalid = !rst && rd_valid_q && (rd_owner_q == OWN_CORE);
  assign bus.host_rvalid = !rst && rd_valid_q && (rd_owner_q == OWN_HOST);
  assign bus.core_rdata  = rst ? 32'h0 : (bus.core_rvalid ? fmt_rdata : core_rdata_q);
  assign bus.host_rdata  = rst ? 32'h0 : (bus.host_rvalid ? bus.ram_rdata : host_rdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= OWN_CORE;
      rd_size_q    <= SZ_WORD;
      rd_sign_q    <= 1'b0;
      rd_off_q     <= 2'b00;
      core_rdata_q <= 32'h0;
      host_rdata_q <= 32'h0;
    end else begin
      starve_q   <= starve_d;
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_owner_q <= host_sel ? OWN_HOST : OWN_CORE;
        rd_size_q  <= host_sel ? SZ_WORD : core_size;
        rd_sign_q  <= host_sel ? 1'b0 : bus.core_sign;
        rd_off_q   <= host_sel ? 2'b00 : core_off;
      end
      if (bus.core_rvalid) core_rdata_q <= fmt_rdata;
      if (bus.host_rvalid) host_rdata_q <= bus.ram_rdata;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well clear of the rising edge.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  dram_arbiter_if #(.ADDR_W(12)) dif ();

  dram_arbiter #(.ADDR_W(12), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_core(input logic req, input logic we, input logic [1:0] size,
                          input logic sign, input logic [11:0] addr, input logic [31:0] wdata);
    dif.core_req   = req;
    dif.core_we    = we;
    dif.core_size  = size;
    dif.core_sign  = sign;
    dif.core_addr  = addr;
    dif.core_wdata = wdata;
  endtask

  task automatic set_host(input logic req, input logic we, input logic lock,
                          input logic [11:0] addr, input logic [31:0] wdata);
    dif.host_req   = req;
    dif.host_we    = we;
    dif.host_lock  = lock;
    dif.host_addr  = addr;
    dif.host_wdata = wdata;
  endtask

  initial begin
    set_core(1'b1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    set_host(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    dif.ram_rdata = 32'h0;

    // Reset: grants and RAM controls forced low, return path cleared.
    @(negedge clk); #1;
    check("rst_core_gnt", dif.core_gnt, 0);
    check("rst_ram_en", dif.ram_en, 0);
    @(negedge clk); #1;
    check("rst_core_rvalid", dif.core_rvalid, 0);
    check("rst_core_rdata", dif.core_rdata, 32'h0);
    check("rst_host_rdata", dif.host_rdata, 32'h0);

    // sb 0xA5 at 0x003
    @(negedge clk);
    rst = 1'b0;
    set_core(1'b1, 1'b1, 2'b00, 1'b0, 12'h003, 32'h0000_00A5);
    #1;
    $display("sb  addr=0x003 be=%b wdata=0x%08h", dif.ram_be, dif.ram_wdata);
    check("sb_gnt", dif.core_gnt, 1);
    check("sb_be", dif.ram_be, 4'b1000);
    check("sb_wdata", dif.ram_wdata, 32'hA5A5_A5A5);
    check("sb_addr", dif.ram_addr, 0);
    check("sb_we", dif.ram_we, 1);

    // sh at 0x002: low half replicated to both halves
    @(negedge clk);
    set_core(1'b1, 1'b1, 2'b01, 1'b0, 12'h002, 32'h1234_ABCD);
    #1;
    $display("sh  addr=0x002 be=%b wdata=0x%08h", dif.ram_be, dif.ram_wdata);
    check("sb_no_rvalid", dif.core_rvalid, 0);
    check("sh_be", dif.ram_be, 4'b1100);
    check("sh_wdata", dif.ram_wdata, 32'hABCD_ABCD);

    // lh signed then lh unsigned back-to-back at 0x002
    @(negedge clk);
    set_core(1'b1, 1'b0, 2'b01, 1'b1, 12'h002, 32'h0);
    #1;
    $display("lh  addr=0x002 sign=1 be=%b en=%b", dif.ram_be, dif.ram_en);
    check("lh_be", dif.ram_be, 4'b1100);
    check("lh_en", dif.ram_en, 1);
    @(negedge clk);
    set_core(1'b1, 1'b0, 2'b01, 1'b0, 12'h002, 32'h0);
    dif.ram_rdata = 32'h8001_1234;
    #1;
    $display("lh  ret rvalid=%b rdata=0x%08h", dif.core_rvalid, dif.core_rdata);
    check("lhs_rvalid", dif.core_rvalid, 1);
    check("lhs_rdata", dif.core_rdata, 32'hFFFF_8001);
    @(negedge clk);
    set_core(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    #1;
    $display("lhu ret rvalid=%b rdata=0x%08h", dif.core_rvalid, dif.core_rdata);
    check("lhu_rvalid", dif.core_rvalid, 1);
    check("lhu_rdata", dif.core_rdata, 32'h0000_8001);
    @(negedge clk);
    dif.ram_rdata = 32'h0;
    #1;
    check("idle_rvalid", dif.core_rvalid, 0);
    check("hold_rdata", dif.core_rdata, 32'h0000_8001);

    // lb signed at 0x001: lane 1 of 0x0000F000 is 0xF0
    @(negedge clk);
    set_core(1'b1, 1'b0, 2'b00, 1'b1, 12'h001, 32'h0);
    #1;
    check("lb_be", dif.ram_be, 4'b0010);
    @(negedge clk);
    set_core(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    dif.ram_rdata = 32'h0000_F000;
    #1;
    $display("lb  ret rvalid=%b rdata=0x%08h", dif.core_rvalid, dif.core_rdata);
    check("lb_rdata", dif.core_rdata, 32'hFFFF_FFF0);

    // Misaligned lw at 0x006
    @(negedge clk);
    set_core(1'b1, 1'b0, 2'b10, 1'b0, 12'h006, 32'h0);
    #1;
    $display("lw  addr=0x006 gnt=%b err=%b en=%b", dif.core_gnt, dif.core_err, dif.ram_en);
    check("mis_gnt", dif.core_gnt, 1);
    check("mis_err", dif.core_err, 1);
    check("mis_en", dif.ram_en, 0);
    @(negedge clk);
    set_core(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    #1;
    check("mis_no_rvalid", dif.core_rvalid, 0);
    check("mis_no_err", dif.core_err, 0);

    // Starvation: core wins 4 cycles, host gets cycle 4, core again cycle 5
    @(negedge clk);
    set_core(1'b1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    set_host(1'b1, 1'b0, 1'b0, 12'h013, 32'h0);
    dif.ram_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      $display("starve cyc=%0d core_gnt=%b host_gnt=%b", k, dif.core_gnt, dif.host_gnt);
      check($sformatf("starve_core_gnt%0d", k), dif.core_gnt, (k == 4) ? 0 : 1);
      check($sformatf("starve_host_gnt%0d", k), dif.host_gnt, (k == 4) ? 1 : 0);
      if (k == 4) begin
        check("host_addr", dif.ram_addr, 10'h004);
        check("host_be", dif.ram_be, 4'b1111);
      end
      if (k == 5) begin
        check("host_rvalid", dif.host_rvalid, 1);
        check("host_rdata", dif.host_rdata, 32'hDEAD_BEEF);
        check("core_no_rvalid", dif.core_rvalid, 0);
      end
    end

    // Lock: host write granted every cycle despite core request
    @(negedge clk);
    set_host(1'b1, 1'b1, 1'b1, 12'h020, 32'h1122_3344);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      $display("lock cyc=%0d core_gnt=%b host_gnt=%b", k, dif.core_gnt, dif.host_gnt);
      check($sformatf("lock_host_gnt%0d", k), dif.host_gnt, 1);
      check($sformatf("lock_core_gnt%0d", k), dif.core_gnt, 0);
      if (k == 0) check("host_wdata", dif.ram_wdata, 32'h1122_3344);
      if (k == 1) check("hostwr_no_rvalid", dif.host_rvalid, 0);
    end

    // Host read, then reset in the return cycle
    @(negedge clk);
    set_core(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    set_host(1'b1, 1'b0, 1'b1, 12'h020, 32'h0);
    #1;
    check("hrd_en", dif.ram_en, 1);
    @(negedge clk);
    rst = 1'b1;
    set_host(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    $display("rst-in-return host_rvalid=%b host_rdata=0x%08h", dif.host_rvalid, dif.host_rdata);
    check("rstret_rvalid", dif.host_rvalid, 0);
    check("rstret_rdata", dif.host_rdata, 32'h0);
    check("rstret_en", dif.ram_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_rvalid", dif.host_rvalid, 0);
    check("post_rst_rdata", dif.host_rdata, 32'h0);
    check("post_rst_core_rdata", dif.core_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width of the data RAM (4 KiB, 1024 words).
REQ-002 Parameter STARVE_MAX, default 4, max consecutive cycles the host waits while the core holds the RAM.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 core_req in 1 / core_we in 1 / core_size in 2 (00 byte, 01 half, 10 word) / core_sign in 1 / core_addr in ADDR_W / core_wdata in 32  MEM-stage request.
REQ-006 core_gnt out 1 / core_err out 1 / core_rvalid out 1 / core_rdata out 32  core response.
REQ-007 host_req in 1 / host_we in 1 / host_lock in 1 / host_addr in ADDR_W / host_wdata in 32  loader/dump port, word-only.
REQ-008 host_gnt out 1 / host_rvalid out 1 / host_rdata out 32  host response.
REQ-009 ram_en out 1 / ram_we out 1 / ram_be out 4 / ram_addr out ADDR_W-2 / ram_wdata out 32 / ram_rdata in 32  four byte-lane single-port RAM, 1-cycle read latency.

Function
REQ-010 Grants SHALL be combinational in the request cycle; at most one of core_gnt/host_gnt high per cycle.
REQ-011 Priority: host when host_lock=1, else host when starve counter = STARVE_MAX, else core, else host.
REQ-012 Starve counter SHALL increment each cycle host_req=1 and host not granted, clear on host_gnt or host_req=0, saturate at STARVE_MAX.
REQ-013 Core alignment: half needs addr[0]=0, word needs addr[1:0]=0, size 11 illegal; violation SHALL pulse core_err with core_gnt, ram_en=0, no rvalid.
REQ-014 ram_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; host always 1111, host_addr[1:0] ignored.
REQ-015 Write data steering: byte replicated to all four lanes, half replicated to both halves, word unchanged.
REQ-016 ram_addr = granted addr[ADDR_W-1:2]; ram_en = granted legal access; ram_we = granted we.
REQ-017 Granted read SHALL register owner, size, sign, addr[1:0]; rvalid to owner exactly 1 cycle later with formatted ram_rdata.
REQ-018 Core read format: select lane(s) by offset, sign- or zero-extend per core_sign; host gets raw word.
REQ-019 Writes produce no rvalid; back-to-back reads SHALL be accepted every cycle (return pipeline, no bubble).
REQ-020 Requests SHALL be held by requester until granted; arbiter keeps no queue.
REQ-021 Ungranted rdata outputs SHALL hold last value; rvalid low.

Reset
REQ-022 On rst: starve counter 0, return register empty, core_rvalid=host_rvalid=0, core_rdata=host_rdata=0.
REQ-023 Reset asserted during a read cycle SHALL suppress that read's rvalid.
REQ-024 Grants and RAM controls are combinational and SHALL be forced low while rst=1.

Structure
REQ-025 Size encodings, lane-mask constants and owner enum SHALL live in the shared core defines package.
REQ-026 Load formatting SHALL be one sub-module, load_align (data, offset, size, sign -> 32-bit result), reusable by the MEM stage.

Verification
REQ-027 Core sb 0xA5 to addr 0x003 -> ram_be=1000, ram_wdata=0xA5A5A5A5, ram_addr=0x000, no rvalid.
REQ-028 Core lh sign=1 at 0x002, ram_rdata=0x8001_1234 -> next cycle core_rvalid=1, core_rdata=0xFFFF8001; sign=0 -> 0x00008001.
REQ-029 Core and host req continuously, lock=0, STARVE_MAX=4 -> core granted cycles 0-3, host cycle 4, counter clears.
REQ-030 host_lock=1 with core_req=1 -> host granted every cycle, core_gnt=0 throughout.
REQ-031 Core lw at 0x006 -> core_err pulse, ram_en=0, no core_rvalid.
REQ-032 rst asserted in cycle after host read grant -> host_rvalid stays 0, all outputs 0.
